// File: rtl/pattern_hit_logger.sv
// Counts rising edges of the pattern detector's hit line and logs a cycle
// timestamp for each into a small FIFO drained through a valid/ready port.
module pattern_hit_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       hit,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W-1:0]            rd_data,
    output logic [CNT_W-1:0]           hit_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] ts;
    logic            hit_q;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic evt;
    logic full;
    logic pop;
    logic push;

    assign evt  = hit & ~hit_q;
    assign full = (level == LW'(DEPTH));
    assign pop  = rd_valid & rd_ready;
    // A full FIFO still accepts the event when the head leaves in the same cycle.
    assign push = evt & (~full | pop);

    assign rd_valid   = (level != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts        <= '0;
            hit_q     <= 1'b0;
            hit_count <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            hit_q <= hit;
            if (clr) begin
                ts        <= '0;
                hit_count <= '0;
                overflow  <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
            end else begin
                ts <= ts + 1'b1;
                if (evt && (hit_count != '1))
                    hit_count <= hit_count + 1'b1;
                if (evt && !push)
                    overflow <= 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    level <= level + 1'b1;
                else if (pop && !push)
                    level <= level - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; the level counter alone decides
    // which entries are meaningful, and rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= ts;
    end

endmodule

// File: tb/tb_pattern_hit_logger.sv
// Directed bench for pattern_hit_logger: a wide instance (a) and a narrow
// instance (b, TS_W=4, CNT_W=3) checked against a timestamp scoreboard.
module tb_pattern_hit_logger;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        clr_a = 0, hit_a = 0, rd_ready_a = 0;
    logic        rd_valid_a, overflow_a;
    logic [15:0] rd_data_a;
    logic [7:0]  hit_count_a;
    logic [3:0]  fifo_level_a;

    logic        clr_b = 0, hit_b = 0, rd_ready_b = 0;
    logic        rd_valid_b, overflow_b;
    logic [3:0]  rd_data_b;
    logic [2:0]  hit_count_b;
    logic [3:0]  fifo_level_b;

    int checks = 0;
    int errors = 0;

    // scoreboard / reference state, index 0 = a, 1 = b
    int q_a[$];
    int q_b[$];
    int ts_m[2];
    int cnt_m[2];
    bit ovf_m[2];
    bit hq_m[2];
    int ts_mask[2] = '{32'hFFFF, 32'hF};
    int cnt_max[2] = '{255, 7};
    int t_mark;

    always #5 clk = ~clk;

    pattern_hit_logger #(.DEPTH(8), .TS_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .clr(clr_a), .hit(hit_a), .rd_ready(rd_ready_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .hit_count(hit_count_a),
        .fifo_level(fifo_level_a), .overflow(overflow_a)
    );

    pattern_hit_logger #(.DEPTH(8), .TS_W(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .clr(clr_b), .hit(hit_b), .rd_ready(rd_ready_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .hit_count(hit_count_b),
        .fifo_level(fifo_level_b), .overflow(overflow_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            ts_m[d] = 0; cnt_m[d] = 0; ovf_m[d] = 0; hq_m[d] = 0;
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic int q_head(input int d);
        if (q_size(d) == 0) return 0;
        return (d == 0) ? q_a[0] : q_b[0];
    endfunction

    // Advance the reference by one cycle using the inputs currently driven.
    task automatic model(input int d, input bit h, input bit r, input bit c,
                         input logic [31:0] rdd);
        int exp;
        if (c) begin
            ts_m[d] = 0; cnt_m[d] = 0; ovf_m[d] = 0;
            if (d == 0) q_a.delete(); else q_b.delete();
        end else begin
            if (r && q_size(d) != 0) begin
                exp = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check(d == 0 ? "pop_data_a" : "pop_data_b", rdd, exp);
            end
            if (h && !hq_m[d]) begin
                if (cnt_m[d] < cnt_max[d]) cnt_m[d]++;
                if (q_size(d) < 8) begin
                    if (d == 0) q_a.push_back(ts_m[d]); else q_b.push_back(ts_m[d]);
                end else begin
                    ovf_m[d] = 1;
                end
            end
            ts_m[d] = (ts_m[d] + 1) & ts_mask[d];
        end
        hq_m[d] = h;
    endtask

    task automatic check_all();
        check("valid_a", 32'(rd_valid_a), 32'(q_size(0) != 0));
        check("data_a",  32'(rd_data_a),  q_head(0));
        check("level_a", 32'(fifo_level_a), q_size(0));
        check("count_a", 32'(hit_count_a), cnt_m[0]);
        check("ovf_a",   32'(overflow_a), 32'(ovf_m[0]));
        check("valid_b", 32'(rd_valid_b), 32'(q_size(1) != 0));
        check("data_b",  32'(rd_data_b),  q_head(1));
        check("level_b", 32'(fifo_level_b), q_size(1));
        check("count_b", 32'(hit_count_b), cnt_m[1]);
        check("ovf_b",   32'(overflow_b), 32'(ovf_m[1]));
    endtask

    task automatic tick();
        model(0, hit_a, rd_ready_a, clr_a, 32'(rd_data_a));
        model(1, hit_b, rd_ready_b, clr_b, 32'(rd_data_b));
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_ts(input int d, input int v);
        int n = 0;
        while (ts_m[d] != v && n < 40) begin
            tick();
            n++;
        end
        check("wait_ts_bound", 32'(ts_m[d] == v), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        // hit already high when reset releases: counts as an event at ts=0
        hit_b = 1;
        rst = 0;
        tick();
        hit_b = 0;

        // single hit at ts=5, then hold, then pop
        wait_ts(0, 5);
        hit_a = 1;
        tick();
        hit_a = 0;
        check("t1_valid", 32'(rd_valid_a), 32'd1);
        check("t1_data",  32'(rd_data_a), 32'd5);
        check("t1_count", 32'(hit_count_a), 32'd1);
        check("t1_level", 32'(fifo_level_a), 32'd1);
        repeat (3) begin
            tick();
            check("t1_hold", 32'(rd_data_a), 32'd5);
        end
        rd_ready_a = 1;
        tick();
        rd_ready_a = 0;
        check("t1_empty_valid", 32'(rd_valid_a), 32'd0);
        check("t1_empty_data",  32'(rd_data_a), 32'd0);

        // hit held high for ts=10..14 yields one entry
        wait_ts(0, 10);
        hit_a = 1;
        repeat (5) tick();
        hit_a = 0;
        tick();
        check("t2_count", 32'(hit_count_a), 32'd2);
        check("t2_level", 32'(fifo_level_a), 32'd1);
        check("t2_data",  32'(rd_data_a), 32'd10);
        rd_ready_a = 1;
        tick();
        rd_ready_a = 0;

        // nine isolated hits with no reads: eight kept, one dropped
        repeat (9) begin
            hit_a = 1; tick();
            hit_a = 0; tick();
        end
        check("t3_level", 32'(fifo_level_a), 32'd8);
        check("t3_ovf",   32'(overflow_a), 32'd1);
        check("t3_count", 32'(hit_count_a), 32'd11);
        rd_ready_a = 1;
        repeat (8) tick();
        rd_ready_a = 0;
        check("t3_drained", 32'(rd_valid_a), 32'd0);
        check("t3_ovf_sticky", 32'(overflow_a), 32'd1);

        // clear, refill, then hit and pop together on a full FIFO
        clr_a = 1;
        tick();
        clr_a = 0;
        check("clr_ovf", 32'(overflow_a), 32'd0);
        repeat (8) begin
            hit_a = 1; tick();
            hit_a = 0; tick();
        end
        t_mark = ts_m[0];
        hit_a = 1;
        rd_ready_a = 1;
        tick();
        hit_a = 0;
        check("t4_level", 32'(fifo_level_a), 32'd8);
        check("t4_ovf",   32'(overflow_a), 32'd0);
        repeat (7) tick();
        check("t4_last", 32'(rd_data_a), 32'(t_mark));
        tick();
        rd_ready_a = 0;
        check("t4_empty", 32'(rd_valid_a), 32'd0);

        // clr together with a hit edge discards the event; ts restarts at 0
        hit_a = 1;
        clr_a = 1;
        tick();
        clr_a = 0;
        check("t5_count", 32'(hit_count_a), 32'd0);
        check("t5_level", 32'(fifo_level_a), 32'd0);
        tick();
        hit_a = 0;
        tick();
        hit_a = 1;
        tick();
        hit_a = 0;
        check("t5_ts_restart", 32'(rd_data_a), 32'd2);
        rd_ready_a = 1;
        tick();
        rd_ready_a = 0;

        // narrow instance: counter saturation
        repeat (10) begin
            hit_b = 1; tick();
            hit_b = 0; tick();
        end
        check("t6_sat", 32'(hit_count_b), 32'd7);
        hit_b = 1;
        clr_b = 1;
        tick();
        clr_b = 0;
        hit_b = 0;
        check("t6_clr_count", 32'(hit_count_b), 32'd0);
        check("t6_clr_level", 32'(fifo_level_b), 32'd0);
        check("t6_clr_ovf",   32'(overflow_b), 32'd0);

        // timestamp wrap: hits at cycles 14 and 18 log 14 and 2
        wait_ts(1, 14);
        hit_b = 1; tick();
        hit_b = 0;
        wait_ts(1, 2);
        hit_b = 1; tick();
        hit_b = 0;
        check("t7_level", 32'(fifo_level_b), 32'd2);
        check("t7_first", 32'(rd_data_b), 32'd14);
        rd_ready_b = 1;
        tick();
        rd_ready_b = 0;
        check("t7_second", 32'(rd_data_b), 32'd2);

        // asynchronous reset mid-drain
        rd_ready_b = 1;
        rst = 1;
        #1;
        model_reset();
        check_all();
        rd_ready_b = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_hit_logger.md
# pattern_hit_logger

Downstream consumer of the serial pattern detector. Takes the detector's single-cycle `hit` output and counts detections. Each detection is stamped with a free-running cycle timestamp and queued in a small FIFO. Software or a downstream stage drains the FIFO through a valid/ready read port.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_W`, 16: timestamp width.
- `CNT_W`, 8: hit counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `clr`  in  1  synchronous clear; highest priority after `rst`.
- `hit`  in  1  detector output; high for one or more cycles per detection.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  FIFO non-empty; head entry is presented.
- `rd_data`  out  TS_W  timestamp of the head entry.
- `hit_count`  out  CNT_W  number of detections; saturating.
- `fifo_level`  out  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.
- `overflow`  out  1  sticky; set when an event is dropped on a full FIFO.

## Operation
- Timestamp counter `ts`:
  - Increments by 1 every cycle.
  - Wraps from 2^TS_W−1 to 0.
- Event detection:
  - `hit_q` registers `hit` every cycle, including during `clr`.
  - An event is `hit & ~hit_q`, i.e. a rising edge.
  - A `hit` held high for several cycles gives exactly one event.
- On an event:
  - `hit_count` increments, saturating at 2^CNT_W−1.
  - The current-cycle `ts` value (pre-increment) is pushed into the FIFO.
- Push rules:
  - Not full: the write succeeds.
  - Full and pop in the same cycle: the write succeeds and the level is unchanged.
  - Full and no pop: the event is dropped and `overflow` is set. `hit_count` still increments.
- Pop:
  - Occurs when `rd_valid & rd_ready`.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - `fifo_level` tracks the count: +1 on push-only, −1 on pop-only, unchanged for both or neither.
- Read port:
  - `rd_valid` = (`fifo_level` != 0).
  - `rd_data` = the head entry when `rd_valid` is high, else 0.
  - `rd_data` is held stable while `rd_valid & ~rd_ready`.
  - `rd_ready` is ignored while `rd_valid` is low.
- `clr` asserted:
  - Next state: `ts`=0, `hit_count`=0, `overflow`=0, `fifo_level`=0, pointers=0.
  - An event or pop occurring in a `clr` cycle is discarded.
- `rst` asserted: same state as `clr`, plus `hit_q`=0, applied asynchronously.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_data`=0.
  - `hit_count`=0, `fifo_level`=0, `overflow`=0.
  - Internal: `ts`=0, `hit_q`=0.
- First cycle after `rst` deasserts has `ts`=0.
- Event in cycle N:
  - `hit_count`, `fifo_level`, `rd_valid` update at the edge ending cycle N, so they are visible in cycle N+1.
  - `rd_data` = ts(N) in N+1 if the FIFO was empty.
  - No fall-through: a push to an empty FIFO is never popped in the same cycle.
- Pop in cycle N: the next entry, or `rd_valid`=0, appears in cycle N+1.
- Full-throughput sustained pop: one entry per cycle.
- `overflow` is set at the edge ending the dropped-event cycle and stays set until `clr` or `rst`.
- Edge cases:
  - `ts` wrap: a stored timestamp may be numerically smaller than its predecessor. This is correct, with no special handling.
  - `hit` high during the cycle `rst` releases: `hit_q`=0, so that cycle counts as an event at ts=0.

## Test plan
- Reset, then a one-cycle `hit` at ts=5, `rd_ready`=0 → cycle ts=6: `rd_valid`=1, `rd_data`=5, `hit_count`=1, `fifo_level`=1. Hold `rd_ready`=0 for 3 cycles → `rd_data` stays 5. Pulse `rd_ready` → next cycle `rd_valid`=0, `rd_data`=0.
- `hit` held high for ts=10..14 → exactly one entry (10), `hit_count`=1.
- DEPTH=8: 9 isolated hits at ts=2,4,…,18 with no reads → `fifo_level`=8, `overflow`=1, `hit_count`=9. Drain yields 2,4,…,16 in order, and `overflow` stays 1.
- FIFO full with `rd_ready`=1 in the same cycle as a hit at ts=T → `fifo_level` stays 8, `overflow`=0, last entry read = T.
- `CNT_W`=3 with 10 hits → `hit_count` saturates at 7. Then assert `clr` together with a `hit` rising edge → next cycle `hit_count`=0, `fifo_level`=0, `overflow`=0, ts=0, and no entry is logged.
- `TS_W`=4: hits at cycles 14 and 18 → entries 14 and 2, confirming the wrap. Assert `rst` mid-drain → all outputs return to reset values immediately.
